// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: sequencer states, peripheral
// count, bridge address window and AHB HTRANS encodings.
package bridge_pkg;

  localparam int NSEL = 3;

  localparam logic [31:0] BRIDGE_BASE  = 32'h8000_0000;
  localparam logic [31:0] BRIDGE_LIMIT = 32'h8BFF_FFFF;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WWAIT   = 3'd1,
    ST_WSETUP  = 3'd2,
    ST_WACCESS = 3'd3,
    ST_RSETUP  = 3'd4,
    ST_RACCESS = 3'd5
  } state_e;

  function automatic logic in_bridge_range(input logic [31:0] addr);
    return (addr >= BRIDGE_BASE) && (addr <= BRIDGE_LIMIT);
  endfunction

endpackage

// File: rtl/apb_fsm_controller.sv
// APB master sequencer: turns one qualified AHB transfer at a time into an
// APB SETUP/ACCESS pair, stalling the AHB side through hready_out.
module apb_fsm_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSEL   = 3
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              valid,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [NSEL-1:0]   temp_sel,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  output logic [NSEL-1:0]   psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              hready_out,
  output logic [DATA_W-1:0] hrdata
);
  import bridge_pkg::*;

  state_e            r_state;
  state_e            w_next;
  state_e            w_start;
  logic              w_hready;
  logic              w_accept;
  logic              w_sel_on;
  logic              w_en_on;
  logic              w_wr_on;
  logic [NSEL-1:0]   w_sel_nxt;
  logic [NSEL-1:0]   r_sel;
  logic [NSEL-1:0]   r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = hwrite ? ST_WWAIT : ST_RSETUP;
    case (r_state)
      ST_IDLE:    if (valid) w_next = w_start;
      ST_WWAIT:   w_next = ST_WSETUP;
      ST_WSETUP:  w_next = ST_WACCESS;
      ST_RSETUP:  w_next = ST_RACCESS;
      ST_WACCESS,
      ST_RACCESS: if (pready) w_next = valid ? w_start : ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // APB controls are registered from the next state so they change on the edge
  // that enters SETUP/ACCESS; hready_out is the only combinational handshake.
  always_comb begin
    w_hready = 1'b0;
    case (r_state)
      ST_IDLE:                w_hready = 1'b1;
      ST_WACCESS, ST_RACCESS: w_hready = pready;
      default:                w_hready = 1'b0;
    endcase
    w_accept = valid & w_hready;
    w_sel_on = (w_next == ST_WSETUP) || (w_next == ST_WACCESS) ||
               (w_next == ST_RSETUP) || (w_next == ST_RACCESS);
    w_en_on  = (w_next == ST_WACCESS) || (w_next == ST_RACCESS);
    w_wr_on  = (w_next == ST_WSETUP) || (w_next == ST_WACCESS);
  end

  // A read goes straight to SETUP, so its select must bypass r_sel.
  assign w_sel_nxt = w_accept ? temp_sel : r_sel;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_sel     <= '0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      r_sel     <= w_sel_nxt;
      r_psel    <= w_sel_on ? w_sel_nxt : '0;
      r_penable <= w_en_on;
      r_pwrite  <= w_wr_on;
      if (w_accept)            r_paddr  <= haddr;
      if (r_state == ST_WWAIT) r_pwdata <= hwdata;
    end
  end

  assign psel       = r_psel;
  assign penable    = r_penable;
  assign pwrite     = r_pwrite;
  assign paddr      = r_paddr;
  assign pwdata     = r_pwdata;
  assign hready_out = w_hready;
  assign hrdata     = prdata;

endmodule
